i2c_target: RTL and testbench

- I2C target (slave) endpoint: the responder for our open-drain I2C master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs it, then streams write bytes out to the host logic and requests read bytes from it.
- Sits between the board I2C pins (via tristate pad) and a register file / FIFO in fabric.

---
 rtl/i2c_pkg.sv | 15 +
 rtl/i2c_line_cond.sv | 52 +++++
 rtl/i2c_target.sv | 161 ++++++++++++++++
 tb/tb_i2c_target.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state codes, R/W bit encoding and ACK levels for the I2C target.
package i2c_pkg;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WRITE_ACK = 3'd4;
    localparam logic [2:0] S_READ      = 3'd5;
    localparam logic [2:0] S_READ_ACK  = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: synchroniser, optional agreement filter (I2C_TARGET_GLITCH_FILTER_EN) and edge detect.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic r_prev;
    logic w_level;
    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("i2c_line_cond: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end
    // Idle bus is high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (reset) r_sync <= '1;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] r_cnt;
    logic r_filt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync[SYNC_STAGES-1];
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign w_level = r_filt;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif
    always_ff @(posedge clk) begin
        if (reset) r_prev <= 1'b1;
        else       r_prev <= w_level;
    end
    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target with fixed address, write streaming and read requests.
// Optional glitch filter on SCL/SDA via I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       wr_first,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       stop_det
);
    logic w_scl, w_scl_rise, w_scl_fall, w_sda, w_sda_rise, w_sda_fall, w_start, w_stop;
    logic [2:0] r_state, r_cnt;
    logic [7:0] r_shift, r_wr_data;
    logic r_first, r_ack_on, r_sda_oe, r_busy, r_wr_valid, r_wr_first, r_rd_req, r_stop_det;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(clk), .reset(reset), .i_line(scl_in),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );
    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(clk), .reset(reset), .i_line(sda_in),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_shift    <= 8'h00;
            r_first    <= 1'b0;
            r_ack_on   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_data  <= 8'h00;
            r_wr_valid <= 1'b0;
            r_wr_first <= 1'b0;
            r_rd_req   <= 1'b0;
            r_stop_det <= 1'b0;
        end else begin
            r_wr_valid <= 1'b0;
            r_wr_first <= 1'b0;
            r_rd_req   <= 1'b0;
            r_stop_det <= 1'b0;
            if (w_stop) begin
                r_state    <= S_IDLE;
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b0;
                r_stop_det <= 1'b1;
            end else if (w_start) begin
                r_state  <= S_ADDR;
                r_cnt    <= 3'd7;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_ack_on <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift <= {r_shift[6:0], w_sda};
                        r_cnt   <= r_cnt - 3'd1;
                        if (r_cnt == 3'd0) begin
                            r_state  <= (r_shift[6:0] == ADDR) ? S_ADDR_ACK : S_IDLE;
                            r_busy   <= r_shift[6:0] == ADDR;
                            r_ack_on <= 1'b0;
                        end
                    end
                    // r_ack_on marks the second half of the ACK slot (SDA held low).
                    S_ADDR_ACK: begin
                        if (w_scl_rise && r_ack_on && r_shift[0] == RW_READ) r_rd_req <= 1'b1;
                        if (w_scl_fall) begin
                            r_ack_on <= ~r_ack_on;
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                            end else if (r_shift[0] == RW_WRITE) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_WRITE;
                                r_cnt    <= 3'd7;
                                r_first  <= 1'b1;
                            end else begin
                                r_shift  <= {rd_data[6:0], 1'b0};
                                r_sda_oe <= ~rd_data[7];
                                r_state  <= S_READ;
                                r_cnt    <= 3'd7;
                            end
                        end
                    end
                    S_WRITE: if (w_scl_rise) begin
                        r_shift <= {r_shift[6:0], w_sda};
                        r_cnt   <= r_cnt - 3'd1;
                        if (r_cnt == 3'd0) begin
                            r_wr_data  <= {r_shift[6:0], w_sda};
                            r_wr_valid <= 1'b1;
                            r_wr_first <= r_first;
                            r_first    <= 1'b0;
                            r_state    <= S_WRITE_ACK;
                            r_ack_on   <= 1'b0;
                        end
                    end
                    S_WRITE_ACK: if (w_scl_fall) begin
                        r_ack_on <= ~r_ack_on;
                        r_sda_oe <= ~r_ack_on;
                        if (r_ack_on) begin
                            r_state <= S_WRITE;
                            r_cnt   <= 3'd7;
                        end
                    end
                    S_READ: if (w_scl_fall) begin
                        if (r_cnt == 3'd0) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= S_READ_ACK;
                            r_ack_on <= 1'b0;
                        end else begin
                            r_sda_oe <= ~r_shift[7];
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_cnt    <= r_cnt - 3'd1;
                        end
                    end
                    S_READ_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == NACK) begin
                                r_state <= S_WAIT_STOP;
                            end else begin
                                r_rd_req <= 1'b1;
                                r_ack_on <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_on) begin
                            r_shift  <= {rd_data[6:0], 1'b0};
                            r_sda_oe <= ~rd_data[7];
                            r_state  <= S_READ;
                            r_cnt    <= 3'd7;
                            r_ack_on <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign wr_data  = r_wr_data;
    assign wr_valid = r_wr_valid;
    assign wr_first = r_wr_first;
    assign rd_req   = r_rd_req;
    assign stop_det = r_stop_det;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-level bench for i2c_target with an open-drain master model.
module tb_i2c_target;
    import i2c_pkg::*;
    localparam int Q = 8;

    logic clk = 1'b0, reset = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
    logic sda_oe, busy, wr_valid, wr_first, rd_req, stop_det, sda_line;
    logic [7:0] wr_data;
    logic [7:0] rd_data = 8'h00;
    int total = 0, bad = 0;
    int wr_cnt = 0, rd_cnt = 0, stop_cnt = 0, oe_cyc = 0, busy_cyc = 0;
    logic [8:0] wr_log [0:31];
    logic [7:0] rd_vals [0:7];

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        int         exp_wr;
    } vec_t;
    vec_t vecs [5];

    assign sda_line = m_sda & ~sda_oe;
    always #5 clk = ~clk;

    i2c_target dut (
        .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .busy(busy), .wr_data(wr_data), .wr_valid(wr_valid), .wr_first(wr_first),
        .rd_req(rd_req), .rd_data(rd_data), .stop_det(stop_det)
    );

    // Host side: logs writes and answers read requests from rd_vals in order.
    always @(posedge clk) begin
        if (!reset) begin
            if (wr_valid) begin
                wr_log[wr_cnt[4:0]] <= {wr_first, wr_data};
                wr_cnt <= wr_cnt + 1;
            end
            if (rd_req) begin
                rd_data <= rd_vals[rd_cnt[2:0]];
                rd_cnt  <= rd_cnt + 1;
            end
            if (stop_det) stop_cnt <= stop_cnt + 1;
            if (sda_oe) oe_cyc <= oe_cyc + 1;
            if (busy) busy_cyc <= busy_cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic bit_io(input logic b, input logic glitch, output logic s);
        m_sda = b;
        if (glitch) begin
            repeat (3) @(posedge clk);
            m_scl = 1'b1;
            @(posedge clk);
            m_scl = 1'b0;
            repeat (Q - 4) @(posedge clk);
        end else begin
            wq();
        end
        m_scl = 1'b1; wq();
        s = sda_line; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(d[i], i == glitch_bit, s);
        bit_io(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(1'b1, 1'b0, d[i]);
        bit_io(mack, 1'b0, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic a;
        logic s;
        logic [7:0] d;
        int w0, r0, s0, o0, b0;
        rd_vals[0] = 8'h81; rd_vals[1] = 8'h7E; rd_vals[2] = 8'h22; rd_vals[3] = 8'h00;
        rd_vals[4] = 8'h00; rd_vals[5] = 8'h00; rd_vals[6] = 8'h00; rd_vals[7] = 8'h00;
        vecs[0] = '{7'h42, 8'h00, 1'b0, 1};
        vecs[1] = '{7'h42, 8'hFF, 1'b0, 1};
        vecs[2] = '{7'h43, 8'hFF, 1'b1, 0};
        vecs[3] = '{7'h02, 8'h55, 1'b1, 0};
        vecs[4] = '{7'h42, 8'h80, 1'b0, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst sda_oe", sda_oe, 0);
        check("rst busy", busy, 0);
        check("rst wr_data", wr_data, 0);
        check("rst wr_valid", wr_valid, 0);
        check("rst wr_first", wr_first, 0);
        check("rst rd_req", rd_req, 0);
        check("rst stop_det", stop_det, 0);
        check("rst state", dut.r_state, S_IDLE);
        reset = 1'b0;
        wq();

        for (int v = 0; v < 5; v++) begin
            w0 = wr_cnt; s0 = stop_cnt; o0 = oe_cyc; b0 = busy_cyc;
            i2c_start();
            send_byte({vecs[v].addr, RW_WRITE}, -1, a);
            check("vec addr ack", a, vecs[v].exp_ack);
            send_byte(vecs[v].data, -1, a);
            check("vec data ack", a, vecs[v].exp_ack);
            i2c_stop();
            wq();
            check("vec wr count", wr_cnt - w0, vecs[v].exp_wr);
            if (vecs[v].exp_wr == 1) check("vec wr data", wr_log[w0[4:0]], {1'b1, vecs[v].data});
            check("vec stop_det", stop_cnt - s0, 1);
            check("vec oe seen", oe_cyc - o0 > 0, !vecs[v].exp_ack);
            check("vec busy seen", busy_cyc - b0 > 0, !vecs[v].exp_ack);
            check("vec busy end", busy, 0);
        end

        // Two-byte write then STOP.
        w0 = wr_cnt; s0 = stop_cnt;
        i2c_start();
        send_byte(8'h84, -1, a); check("w2 addr ack", a, ACK);
        send_byte(8'hA5, -1, a); check("w2 b0 ack", a, ACK);
        send_byte(8'h3C, -1, a); check("w2 b1 ack", a, ACK);
        check("w2 busy mid", busy, 1);
        i2c_stop();
        wq();
        check("w2 wr count", wr_cnt - w0, 2);
        check("w2 first", wr_log[w0[4:0]], {1'b1, 8'hA5});
        check("w2 second", wr_log[5'(w0 + 1)], {1'b0, 8'h3C});
        check("w2 stop_det", stop_cnt - s0, 1);
        check("w2 busy end", busy, 0);

        // Read two bytes, ACK the first and NACK the second.
        r0 = rd_cnt;
        i2c_start();
        send_byte(8'h85, -1, a); check("rd addr ack", a, ACK);
        recv_byte(ACK, d); check("rd byte0", d, 8'h81);
        recv_byte(NACK, d); check("rd byte1", d, 8'h7E);
        wq();
        check("rd req count", rd_cnt - r0, 2);
        check("rd wait_stop", dut.r_state, S_WAIT_STOP);
        check("rd sda released", sda_oe, 0);
        i2c_stop();
        wq();

        // Write then repeated START into a read.
        w0 = wr_cnt; r0 = rd_cnt;
        i2c_start();
        send_byte(8'h84, -1, a); check("rs addr ack", a, ACK);
        send_byte(8'h11, -1, a); check("rs data ack", a, ACK);
        check("rs busy before", busy, 1);
        i2c_start();
        check("rs busy after", busy, 0);
        send_byte(8'h85, -1, a); check("rs raddr ack", a, ACK);
        recv_byte(NACK, d); check("rs read", d, 8'h22);
        i2c_stop();
        wq();
        check("rs wr count", wr_cnt - w0, 1);
        check("rs wr data", wr_log[w0[4:0]], {1'b1, 8'h11});
        check("rs rd count", rd_cnt - r0, 1);

        // STOP after four bits of a data byte.
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h84, -1, a); check("ps addr ack", a, ACK);
        for (int i = 0; i < 4; i++) bit_io(1'b1, 1'b0, s);
        i2c_stop();
        wq();
        check("ps wr count", wr_cnt - w0, 0);
        check("ps state", dut.r_state, S_IDLE);
        check("ps sda_oe", sda_oe, 0);
        check("ps busy", busy, 0);

        // Reset while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_io(i == 2 || i == 7, 1'b0, s);
        m_sda = 1'b1;
        #1;
        check("rst ack oe", sda_oe, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst ack released", sda_oe, 0);
        reset = 1'b0;
        m_scl = 1'b1; wq(); wq();
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h84, -1, a); check("post rst addr ack", a, ACK);
        send_byte(8'h5A, -1, a); check("post rst data ack", a, ACK);
        i2c_stop();
        wq();
        check("post rst wr", wr_log[w0[4:0]], {1'b1, 8'h5A});
        check("post rst wr count", wr_cnt - w0, 1);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // One-clk SCL glitch inside a data byte must not shift an extra bit.
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h84, -1, a); check("gl addr ack", a, ACK);
        send_byte(8'h96, 3, a); check("gl data ack", a, ACK);
        i2c_stop();
        wq();
        check("gl wr count", wr_cnt - w0, 1);
        check("gl wr data", wr_log[w0[4:0]], {1'b1, 8'h96});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
